spi_servo_cmd_decoder: RTL and testbench

//   Receives servo commands over SPI (mode CPOL=1, CPHA=0, receive-only) by oversampling SCLK/MOSI/SS in the
//   i_clock domain. Frames 3-byte commands: channel index, pulse high byte, pulse low byte.

---
 rtl/servo_pkg.sv | 27 ++
 rtl/spi_sync_edge.sv | 32 +++
 rtl/spi_servo_cmd_decoder.sv | 187 ++++++++++++++++++
 tb/tb_spi_servo_cmd_decoder.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared constants and types for the SPI servo command decoder.
package servo_pkg;

  localparam int          NUM_CHANNELS_DEF = 12;
  localparam int          IDX_W_DEF        = 4;
  localparam logic [15:0] PULSE_MIN_DEF    = 16'd500;
  localparam logic [15:0] PULSE_MAX_DEF    = 16'd2500;
  localparam int          CMD_BYTES        = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_IDX  = 2'd1,
    ST_HI   = 2'd2,
    ST_LO   = 2'd3
  } state_t;

  function automatic logic [15:0] clamp_pulse(input logic [15:0] raw,
                                              input logic [15:0] lo,
                                              input logic [15:0] hi);
    logic [15:0] r;
    r = raw;
    if (r < lo) r = lo;
    if (r > hi) r = hi;
    return r;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Three-flop synchronizer for one asynchronous SPI pin. Exposes the level
// after two stages and a falling-edge pulse from stages two/three, so every
// SPI pin sees identical delay and their relative ordering is preserved.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic level,
  output logic fall
);

  logic s1, s2, s3;

  // Synchronizer chain, preset to the pin's idle level on reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1 <= RESET_VAL;
      s2 <= RESET_VAL;
      s3 <= RESET_VAL;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign fall  = s3 & ~s2;

endmodule

// File: rtl/spi_servo_cmd_decoder.sv
// SPI (CPOL=1, CPHA=0) receive-only servo command decoder, oversampled in the
// i_clock domain. Frames {index, pulse_hi, pulse_lo} and emits a one-cycle
// write strobe to the pulse register bank.
// Optional feature macro: SERVO_PULSE_CLAMP_EN clamps the pulse width to
// [PULSE_MIN, PULSE_MAX]; otherwise the raw 16-bit value is passed through.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | SS high (or not yet re-armed after reset)
// ST_IDX  | receiving channel index byte
// ST_HI   | receiving pulse width high byte
// ST_LO   | receiving pulse width low byte, commit on completion
module spi_servo_cmd_decoder
  import servo_pkg::*;
#(
  parameter int NUM_CHANNELS = NUM_CHANNELS_DEF,
  parameter int IDX_W        = IDX_W_DEF
`ifdef SERVO_PULSE_CLAMP_EN
  ,
  parameter logic [15:0] PULSE_MIN = PULSE_MIN_DEF,
  parameter logic [15:0] PULSE_MAX = PULSE_MAX_DEF
`endif
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_spi_clock,
  input  logic             i_mosi,
  input  logic             i_select,
  output logic             o_wr_valid,
  output logic [IDX_W-1:0] o_wr_index,
  output logic [15:0]      o_wr_pulse,
  output logic             o_err_index,
  output logic [15:0]      o_cmd_count,
  output logic [7:0]       o_err_count
);

  logic sclk_fall, sclk_level;
  logic ss_level, ss_fall;
  logic mosi_level, mosi_fall;
  logic unused_sync;

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_sclk (
    .clk      (i_clock),
    .reset_n  (i_reset_n),
    .async_in (i_spi_clock),
    .level    (sclk_level),
    .fall     (sclk_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_ss (
    .clk      (i_clock),
    .reset_n  (i_reset_n),
    .async_in (i_select),
    .level    (ss_level),
    .fall     (ss_fall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk      (i_clock),
    .reset_n  (i_reset_n),
    .async_in (i_mosi),
    .level    (mosi_level),
    .fall     (mosi_fall)
  );

  assign unused_sync = ^{sclk_level, ss_fall, mosi_fall};

  state_t      state, next_state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_byte;
  logic [7:0]  byte_val;
  logic [7:0]  idx_byte;
  logic [7:0]  hi_byte;
  logic [1:0]  settle_cnt;
  logic        settled;
  logic        armed;
  logic        sample;
  logic        abort;
  logic        byte_done;
  logic        commit;
  logic        idx_ok;
  logic [15:0] pulse_raw;
  logic [15:0] pulse_out;

  // The synchronizer presets look like "SS high" right after reset; wait
  // until the chain holds real pin values before trusting SS to arm a frame.
  assign settled = (settle_cnt == 2'd3);

  // Next-state and per-cycle control: abort on SS high beats sampling.
  always_comb begin
    next_state = state;
    sample     = 1'b0;
    abort      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!ss_level && armed) next_state = ST_IDX;
      end
      default: begin
        if (ss_level) begin
          abort      = 1'b1;
          next_state = ST_IDLE;
        end else if (sclk_fall) begin
          sample = 1'b1;
          if (bit_cnt == 3'd7) begin
            unique case (state)
              ST_IDX:  next_state = ST_HI;
              ST_HI:   next_state = ST_LO;
              default: next_state = ST_IDX;
            endcase
          end
        end
      end
    endcase
  end

  // Current byte with the incoming bit merged in at its LSB-first position.
  always_comb begin
    byte_val          = shift_byte;
    byte_val[bit_cnt] = mosi_level;
  end

  assign byte_done = sample && (bit_cnt == 3'd7);
  assign commit    = byte_done && (state == ST_LO);
  assign idx_ok    = (32'(idx_byte) < NUM_CHANNELS);
  assign pulse_raw = {hi_byte, byte_val};

`ifdef SERVO_PULSE_CLAMP_EN
  assign pulse_out = clamp_pulse(pulse_raw, PULSE_MIN, PULSE_MAX);
`else
  assign pulse_out = pulse_raw;
`endif

  // State register.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) state <= ST_IDLE;
    else            state <= next_state;
  end

  // Bit assembly, byte capture, commit strobes and counters.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      bit_cnt     <= 3'd0;
      shift_byte  <= 8'd0;
      idx_byte    <= 8'd0;
      hi_byte     <= 8'd0;
      settle_cnt  <= 2'd0;
      armed       <= 1'b0;
      o_wr_valid  <= 1'b0;
      o_wr_index  <= '0;
      o_wr_pulse  <= 16'd0;
      o_err_index <= 1'b0;
      o_cmd_count <= 16'd0;
      o_err_count <= 8'd0;
    end else begin
      o_wr_valid  <= 1'b0;
      o_err_index <= 1'b0;

      if (!settled) settle_cnt <= settle_cnt + 2'd1;
      if (settled && ss_level) armed <= 1'b1;

      if (abort || state == ST_IDLE) begin
        bit_cnt <= 3'd0;
      end else if (sample) begin
        bit_cnt    <= bit_cnt + 3'd1;
        shift_byte <= byte_val;
      end

      if (byte_done) begin
        if (state == ST_IDX) idx_byte <= byte_val;
        if (state == ST_HI)  hi_byte  <= byte_val;
      end

      if (commit) begin
        if (idx_ok) begin
          o_wr_valid  <= 1'b1;
          o_wr_index  <= idx_byte[IDX_W-1:0];
          o_wr_pulse  <= pulse_out;
          o_cmd_count <= o_cmd_count + 16'd1;
        end else begin
          o_err_index <= 1'b1;
          if (o_err_count != 8'hFF) o_err_count <= o_err_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_servo_cmd_decoder.sv
// Directed bench for spi_servo_cmd_decoder; SCLK runs at i_clock/8.
module tb_spi_servo_cmd_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sclk = 1'b1;
  logic        mosi = 1'b0;
  logic        ss = 1'b1;
  logic        wr_valid;
  logic [3:0]  wr_index;
  logic [15:0] wr_pulse;
  logic        err_index;
  logic [15:0] cmd_count;
  logic [7:0]  err_count;

  int errors = 0;
  int checks = 0;
  int n_valid = 0;
  int n_err = 0;
  logic [3:0]  mon_idx[$];
  logic [15:0] mon_pulse[$];

  spi_servo_cmd_decoder dut (
    .i_clock     (clk),
    .i_reset_n   (rst_n),
    .i_spi_clock (sclk),
    .i_mosi      (mosi),
    .i_select    (ss),
    .o_wr_valid  (wr_valid),
    .o_wr_index  (wr_index),
    .o_wr_pulse  (wr_pulse),
    .o_err_index (err_index),
    .o_cmd_count (cmd_count),
    .o_err_count (err_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && wr_valid) begin
      n_valid++;
      mon_idx.push_back(wr_index);
      mon_pulse.push_back(wr_pulse);
    end
    if (rst_n && err_index) n_err++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    mosi = b;
    tick(4);
    sclk = 1'b0;
    tick(4);
    sclk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic ss_low();
    ss = 1'b0;
    tick(4);
  endtask

  task automatic ss_high();
    tick(4);
    ss = 1'b1;
    tick(8);
  endtask

  task automatic send_cmd(input logic [7:0] idx, input logic [15:0] pulse);
    send_byte(idx);
    send_byte(pulse[15:8]);
    send_byte(pulse[7:0]);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(3);
    checks++;
    if ({wr_valid, err_index, wr_index, wr_pulse, cmd_count, err_count} !== 46'd0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%0b err=%0b idx=%0d pulse=%0d cmd=%0d errc=%0d, want all 0",
               wr_valid, err_index, wr_index, wr_pulse, cmd_count, err_count);
    end
    rst_n = 1'b1;
    tick(6);
  endtask

  task automatic test_single_latency();
    logic [7:0] lo;
    logic       v1, v2, v3;
    int         base;
    base = n_valid;
    lo = 8'hDC;
    ss_low();
    send_byte(8'h03);
    send_byte(8'h05);
    for (int i = 0; i < 7; i++) send_bit(lo[i]);
    mosi = lo[7];
    tick(4);
    sclk = 1'b0;
    tick(1); v1 = wr_valid;
    tick(1); v2 = wr_valid;
    tick(1); v3 = wr_valid;
    checks++;
    if ({v1, v2, v3} !== 3'b001) begin
      errors++;
      $display("FAIL latency: strobe pattern over cycles 1..3 got %b want 001", {v1, v2, v3});
    end
    tick(3);
    sclk = 1'b1;
    ss_high();
    checks++;
    if (wr_index !== 4'd3 || wr_pulse !== 16'd1500) begin
      errors++;
      $display("FAIL single_data: got idx=%0d pulse=%0d want idx=3 pulse=1500", wr_index, wr_pulse);
    end
    checks++;
    if (cmd_count !== 16'd1 || (n_valid - base) != 1) begin
      errors++;
      $display("FAIL single_count: got cmd=%0d strobes=%0d want cmd=1 strobes=1", cmd_count, n_valid - base);
    end
  endtask

  task automatic test_bad_index();
    int bv, be;
    bv = n_valid; be = n_err;
    ss_low();
    send_cmd(8'h0C, 16'h05DC);
    ss_high();
    checks++;
    if ((n_err - be) != 1 || (n_valid - bv) != 0) begin
      errors++;
      $display("FAIL bad_index_strobes: got err=%0d valid=%0d want err=1 valid=0", n_err - be, n_valid - bv);
    end
    checks++;
    if (err_count !== 8'd1 || cmd_count !== 16'd1) begin
      errors++;
      $display("FAIL bad_index_counts: got errc=%0d cmd=%0d want errc=1 cmd=1", err_count, cmd_count);
    end
    checks++;
    if (wr_index !== 4'd3 || wr_pulse !== 16'd1500) begin
      errors++;
      $display("FAIL bad_index_hold: got idx=%0d pulse=%0d want idx=3 pulse=1500", wr_index, wr_pulse);
    end
  endtask

  task automatic test_partial_abort();
    logic [7:0] hb;
    int bv;
    bv = n_valid;
    hb = 8'h03;
    ss_low();
    send_byte(8'h01);
    for (int i = 0; i < 5; i++) send_bit(hb[i]);
    ss_high();
    ss_low();
    send_cmd(8'h01, 16'h03E8);
    ss_high();
    checks++;
    if ((n_valid - bv) != 1 || wr_index !== 4'd1 || wr_pulse !== 16'd1000) begin
      errors++;
      $display("FAIL partial_abort: got strobes=%0d idx=%0d pulse=%0d want 1, 1, 1000",
               n_valid - bv, wr_index, wr_pulse);
    end
    checks++;
    if (cmd_count !== 16'd2 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL partial_counts: got cmd=%0d errc=%0d want cmd=2 errc=1", cmd_count, err_count);
    end
  endtask

  task automatic test_back_to_back();
    int b;
    b = mon_idx.size();
    ss_low();
    send_cmd(8'h00, 16'h07D0);
    send_cmd(8'h0B, 16'h0258);
    ss_high();
    checks++;
    if (mon_idx.size() != b + 2) begin
      errors++;
      $display("FAIL b2b_count: got strobes=%0d want 2", mon_idx.size() - b);
    end else begin
      checks++;
      if (mon_idx[b] !== 4'd0 || mon_pulse[b] !== 16'd2000) begin
        errors++;
        $display("FAIL b2b_first: got (%0d,%0d) want (0,2000)", mon_idx[b], mon_pulse[b]);
      end
      checks++;
      if (mon_idx[b+1] !== 4'd11 || mon_pulse[b+1] !== 16'd600) begin
        errors++;
        $display("FAIL b2b_second: got (%0d,%0d) want (11,600)", mon_idx[b+1], mon_pulse[b+1]);
      end
    end
    checks++;
    if (cmd_count !== 16'd4) begin
      errors++;
      $display("FAIL b2b_cmd_count: got %0d want 4", cmd_count);
    end
  endtask

  task automatic test_clamp();
    logic [15:0] exp_lo, exp_hi;
`ifdef SERVO_PULSE_CLAMP_EN
    exp_lo = 16'd500;
    exp_hi = 16'd2500;
`else
    exp_lo = 16'd100;
    exp_hi = 16'd5000;
`endif
    ss_low();
    send_cmd(8'h04, 16'h0064);
    ss_high();
    checks++;
    if (wr_index !== 4'd4 || wr_pulse !== exp_lo) begin
      errors++;
      $display("FAIL clamp_low: got (%0d,%0d) want (4,%0d)", wr_index, wr_pulse, exp_lo);
    end
    ss_low();
    send_cmd(8'h05, 16'h1388);
    ss_high();
    checks++;
    if (wr_index !== 4'd5 || wr_pulse !== exp_hi) begin
      errors++;
      $display("FAIL clamp_high: got (%0d,%0d) want (5,%0d)", wr_index, wr_pulse, exp_hi);
    end
    ss_low();
    send_cmd(8'h06, 16'h01F4);
    ss_high();
    checks++;
    if (wr_index !== 4'd6 || wr_pulse !== 16'd500 || cmd_count !== 16'd7) begin
      errors++;
      $display("FAIL clamp_edge: got (%0d,%0d) cmd=%0d want (6,500) cmd=7", wr_index, wr_pulse, cmd_count);
    end
  endtask

  task automatic test_abort_same_cycle();
    logic [7:0] lo;
    int bv, be;
    bv = n_valid; be = n_err;
    lo = 8'hE8;
    ss_low();
    send_byte(8'h01);
    send_byte(8'h03);
    for (int i = 0; i < 7; i++) send_bit(lo[i]);
    mosi = lo[7];
    tick(4);
    sclk = 1'b0;
    ss = 1'b1;
    tick(8);
    sclk = 1'b1;
    tick(8);
    checks++;
    if ((n_valid - bv) != 0 || (n_err - be) != 0 || cmd_count !== 16'd7) begin
      errors++;
      $display("FAIL abort_same_cycle: got valid=%0d err=%0d cmd=%0d want 0, 0, 7",
               n_valid - bv, n_err - be, cmd_count);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bv, be;
    ss_low();
    send_byte(8'h02);
    send_bit(1'b1);
    send_bit(1'b0);
    rst_n = 1'b0;
    tick(3);
    checks++;
    if ({wr_valid, err_index, wr_index, wr_pulse, cmd_count, err_count} !== 46'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got idx=%0d pulse=%0d cmd=%0d errc=%0d want all 0",
               wr_index, wr_pulse, cmd_count, err_count);
    end
    rst_n = 1'b1;
    tick(6);
    bv = n_valid;
    send_cmd(8'h09, 16'h05DC);
    ss_high();
    checks++;
    if ((n_valid - bv) != 0 || cmd_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_needs_ss_edge: got strobes=%0d cmd=%0d want 0, 0", n_valid - bv, cmd_count);
    end
    ss_low();
    send_cmd(8'h02, 16'h05DC);
    ss_high();
    checks++;
    if ((n_valid - bv) != 1 || wr_index !== 4'd2 || wr_pulse !== 16'd1500 || cmd_count !== 16'd1) begin
      errors++;
      $display("FAIL reset_then_frame: got strobes=%0d (%0d,%0d) cmd=%0d want 1 (2,1500) cmd=1",
               n_valid - bv, wr_index, wr_pulse, cmd_count);
    end
    be = n_err;
    ss_low();
    for (int k = 0; k < 256; k++) send_cmd(8'hFF, 16'h0000);
    ss_high();
    checks++;
    if (err_count !== 8'd255 || (n_err - be) != 256) begin
      errors++;
      $display("FAIL err_saturate: got errc=%0d strobes=%0d want 255 and 256", err_count, n_err - be);
    end
    checks++;
    if (cmd_count !== 16'd1 || wr_index !== 4'd2 || wr_pulse !== 16'd1500) begin
      errors++;
      $display("FAIL err_hold: got cmd=%0d (%0d,%0d) want cmd=1 (2,1500)", cmd_count, wr_index, wr_pulse);
    end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_bad_index();
    test_partial_abort();
    test_back_to_back();
    test_clamp();
    test_abort_same_cycle();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
